// File: rtl/store_unit_pkg.sv
// Shared store-engine definitions: size encoding (same as the LOAD_* constants),
// lane-select width, FSM states and the alignment helper.
package store_unit_pkg;

    localparam int LANE_SEL_W = 4;

    typedef enum logic [1:0] {
        STORE_NONE = 2'd0,
        STORE_BYTE = 2'd1,
        STORE_HALF = 2'd2,
        STORE_WORD = 2'd3
    } store_size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } store_state_t;

    // Only alignment is checked; the address range is left to the bus fabric.
    function automatic logic is_misaligned(input store_size_t size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            STORE_HALF: bad = addr_lo[0];
            STORE_WORD: bad = (addr_lo != 2'b00);
            default:    bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_steer.sv
// Little-endian byte-lane steering: size + addr[1:0] + right-justified data
// to lane strobes and replicated write data. Purely combinational.
module store_lane_steer
    import store_unit_pkg::*;
(
    input  store_size_t             size,
    input  logic [1:0]              addr_lo,
    input  logic [31:0]             data,
    output logic [LANE_SEL_W-1:0]   stb,
    output logic [31:0]             dat
);

    // Data is replicated across all lanes so the strobes alone select the target bytes.
    always_comb begin
        stb = '0;
        dat = '0;
        case (size)
            STORE_BYTE: begin
                stb = LANE_SEL_W'(1) << addr_lo;
                dat = {4{data[7:0]}};
            end
            STORE_HALF: begin
                stb = addr_lo[1] ? 4'b1100 : 4'b0011;
                dat = {2{data[15:0]}};
            end
            STORE_WORD: begin
                stb = 4'b1111;
                dat = data;
            end
            default: begin
                stb = '0;
                dat = '0;
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Execute-stage store engine: alignment check, lane steering and one Wishbone
// write cycle, finishing with a one-cycle done or error pulse.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    output logic [31:0]             o_wb_addr,
    output logic                    o_wb_cyc,
    output logic [LANE_SEL_W-1:0]   o_wb_stb,
    output logic                    o_wb_we,
    output logic [31:0]             o_wb_dat,
    input  logic [31:0]             i_wb_dat,
    input  logic                    i_wb_ack,
    input  logic                    i_wb_err,
    input  logic [1:0]              i_store,
    input  logic [31:0]             i_data,
    input  logic [31:0]             i_addr,
    output logic                    o_done,
    output logic                    o_error,
    output logic                    o_busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    store_state_t            state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             dat_q, dat_d;
    logic [LANE_SEL_W-1:0]   stb_q, stb_d;
    logic                    cyc_q, cyc_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    store_size_t             req_size;
    logic [LANE_SEL_W-1:0]   steer_stb;
    logic [31:0]             steer_dat;
    logic                    timeout_hit;
    logic                    unused_wb_dat;

    assign req_size      = store_size_t'(i_store);
    assign unused_wb_dat = ^i_wb_dat;
    assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_VAL);

    store_lane_steer u_steer (
        .size    (req_size),
        .addr_lo (i_addr[1:0]),
        .data    (i_data),
        .stb     (steer_stb),
        .dat     (steer_dat)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            dat_q   <= '0;
            stb_q   <= '0;
            cyc_q   <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            stb_q   <= stb_d;
            cyc_q   <= cyc_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Bus signals are registered on request and held until ack/err/timeout; err beats ack.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dat_d   = dat_q;
        stb_d   = stb_q;
        cyc_d   = cyc_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_size != STORE_NONE) begin
                    if (is_misaligned(req_size, i_addr[1:0])) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_BUS;
                        cnt_d   = '0;
                        addr_d  = {i_addr[31:2], 2'b00};
                        dat_d   = steer_dat;
                        stb_d   = steer_stb;
                        cyc_d   = 1'b1;
                    end
                end
            end
            ST_BUS: begin
                if (i_wb_err || i_wb_ack || timeout_hit) begin
                    state_d = ST_RESP;
                    addr_d  = '0;
                    dat_d   = '0;
                    stb_d   = '0;
                    cyc_d   = 1'b0;
                    if (i_wb_err || timeout_hit) begin
                        error_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = '0;
            end
        endcase
    end

    assign o_wb_addr = addr_q;
    assign o_wb_dat  = dat_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_cyc  = cyc_q;
    assign o_wb_we   = cyc_q;
    assign o_done    = done_q;
    assign o_error   = error_q;
    assign o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit (TIMEOUT_CYCLES=4): lane steering,
// misalignment, bus error, ack/err tie, timeout and mid-cycle reset.
module tb_store_unit;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] o_wb_addr;
    logic        o_wb_cyc;
    logic [3:0]  o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_dat;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack;
    logic        i_wb_err;
    logic [1:0]  i_store;
    logic [31:0] i_data;
    logic [31:0] i_addr;
    logic        o_done;
    logic        o_error;
    logic        o_busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .o_wb_addr (o_wb_addr),
        .o_wb_cyc  (o_wb_cyc),
        .o_wb_stb  (o_wb_stb),
        .o_wb_we   (o_wb_we),
        .o_wb_dat  (o_wb_dat),
        .i_wb_dat  (i_wb_dat),
        .i_wb_ack  (i_wb_ack),
        .i_wb_err  (i_wb_err),
        .i_store   (i_store),
        .i_data    (i_data),
        .i_addr    (i_addr),
        .o_done    (o_done),
        .o_error   (o_error),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Advance one clock and settle just past the edge before sampling or driving.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [1:0] store, input logic [31:0] addr, input logic [31:0] data);
        i_store = store;
        i_addr  = addr;
        i_data  = data;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Checks the registered bus request one cycle after it was issued.
    task automatic check_bus(input string tag, input logic [31:0] addr, input logic [3:0] stb, input logic [31:0] dat);
        check_output({tag, " cyc"},  32'(o_wb_cyc),  32'd1);
        check_output({tag, " we"},   32'(o_wb_we),   32'd1);
        check_output({tag, " addr"}, o_wb_addr,      addr);
        check_output({tag, " stb"},  32'(o_wb_stb),  32'(stb));
        check_output({tag, " dat"},  o_wb_dat,       dat);
        check_output({tag, " busy"}, 32'(o_busy),    32'd1);
    endtask

    // Zero-wait-state completion: ack in the first bus cycle, done in the next.
    task automatic finish_with_ack(input string tag);
        i_wb_ack = 1'b1;
        tick();
        i_wb_ack = 1'b0;
        check_output({tag, " done"}, 32'(o_done),   32'd1);
        check_output({tag, " err"},  32'(o_error),  32'd0);
        check_output({tag, " cyc"},  32'(o_wb_cyc), 32'd0);
        tick();
        check_output({tag, " idle"}, 32'(o_busy),   32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_reset  = 1'b1;
        i_wb_dat = 32'h0;
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        apply_stimulus(2'd0, 32'h0, 32'h0);
        tick();
        tick();
        check_output("rst addr",  o_wb_addr,          32'h0);
        check_output("rst dat",   o_wb_dat,           32'h0);
        check_output("rst stb",   32'(o_wb_stb),      32'h0);
        check_output("rst cyc",   32'(o_wb_cyc),      32'h0);
        check_output("rst we",    32'(o_wb_we),       32'h0);
        check_output("rst pulse", 32'({o_done, o_error}), 32'h0);
        check_output("rst busy",  32'(o_busy),        32'h0);
        i_reset = 1'b0;
        tick();

        // Aligned word, ack two cycles after cyc rises.
        apply_stimulus(2'd3, 32'h0000_0100, 32'hDEAD_BEEF);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        check_bus("word", 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
        check_output("word done c1", 32'(o_done), 32'd0);
        tick();
        apply_stimulus(2'd1, 32'h0000_0203, 32'h0000_0077);
        check_output("word done c2", 32'(o_done), 32'd0);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        check_output("word ignore addr", o_wb_addr,     32'h0000_0100);
        check_output("word ignore stb",  32'(o_wb_stb), 32'hF);
        i_wb_ack = 1'b1;
        tick();
        i_wb_ack = 1'b0;
        check_output("word done",   32'(o_done),   32'd1);
        check_output("word cyc lo", 32'(o_wb_cyc), 32'd0);
        check_output("word err",    32'(o_error),  32'd0);
        check_output("word resp busy", 32'(o_busy), 32'd1);
        tick();
        check_output("word done once", 32'(o_done), 32'd0);
        check_output("word busy lo",   32'(o_busy), 32'd0);

        // Byte lanes at each offset.
        apply_stimulus(2'd1, 32'h0000_0203, 32'h0000_00A5);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        check_bus("byte3", 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5);
        finish_with_ack("byte3");
        apply_stimulus(2'd1, 32'h0000_0200, 32'h0000_003C);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        check_bus("byte0", 32'h0000_0200, 4'b0001, 32'h3C3C_3C3C);
        finish_with_ack("byte0");
        apply_stimulus(2'd1, 32'h0000_0201, 32'hFFFF_FF5A);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        check_bus("byte1", 32'h0000_0200, 4'b0010, 32'h5A5A_5A5A);
        finish_with_ack("byte1");
        apply_stimulus(2'd1, 32'h0000_0202, 32'h0000_0011);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        check_bus("byte2", 32'h0000_0200, 4'b0100, 32'h1111_1111);
        finish_with_ack("byte2");

        // Half-word lanes.
        apply_stimulus(2'd2, 32'h0000_0302, 32'h0000_1234);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        check_bus("half2", 32'h0000_0300, 4'b1100, 32'h1234_1234);
        finish_with_ack("half2");
        apply_stimulus(2'd2, 32'h0000_0300, 32'h5555_ABCD);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        check_bus("half0", 32'h0000_0300, 4'b0011, 32'hABCD_ABCD);
        finish_with_ack("half0");

        // Misaligned half and word: error pulse only, no bus activity.
        apply_stimulus(2'd2, 32'h0000_0301, 32'h0000_1234);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        check_output("mis half err",  32'(o_error),  32'd1);
        check_output("mis half cyc",  32'(o_wb_cyc), 32'd0);
        check_output("mis half busy", 32'(o_busy),   32'd0);
        tick();
        check_output("mis half err once", 32'(o_error), 32'd0);
        apply_stimulus(2'd3, 32'h0000_0402, 32'hCAFE_F00D);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        check_output("mis word err",  32'(o_error),  32'd1);
        check_output("mis word done", 32'(o_done),   32'd0);
        check_output("mis word cyc",  32'(o_wb_cyc), 32'd0);
        check_output("mis word busy", 32'(o_busy),   32'd0);
        tick();
        check_output("mis word err once", 32'(o_error),  32'd0);
        check_output("mis word cyc2",     32'(o_wb_cyc), 32'd0);

        // Bus error alone.
        apply_stimulus(2'd3, 32'h0000_0500, 32'h0000_0001);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        check_output("err cyc", 32'(o_wb_cyc), 32'd1);
        i_wb_err = 1'b1;
        tick();
        i_wb_err = 1'b0;
        check_output("err err",  32'(o_error),  32'd1);
        check_output("err done", 32'(o_done),   32'd0);
        check_output("err cyc lo", 32'(o_wb_cyc), 32'd0);
        tick();
        check_output("err clear", 32'(o_error), 32'd0);

        // Ack and err together: err wins; next request accepted right after RESP.
        apply_stimulus(2'd3, 32'h0000_0504, 32'h0000_0002);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        i_wb_ack = 1'b1;
        i_wb_err = 1'b1;
        tick();
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        check_output("tie err",  32'(o_error), 32'd1);
        check_output("tie done", 32'(o_done),  32'd0);
        tick();
        apply_stimulus(2'd1, 32'h0000_0600, 32'h0000_00C3);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        check_bus("after tie", 32'h0000_0600, 4'b0001, 32'hC3C3_C3C3);
        finish_with_ack("after tie");

        // Timeout: silent slave, error 5 cycles after cyc rises.
        apply_stimulus(2'd3, 32'h0000_0700, 32'h7777_7777);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        check_output("to cyc c1", 32'(o_wb_cyc), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check_output("to cyc c5", 32'(o_wb_cyc), 32'd1);
        check_output("to err c5", 32'(o_error),  32'd0);
        tick();
        check_output("to err c6", 32'(o_error),  32'd1);
        check_output("to cyc c6", 32'(o_wb_cyc), 32'd0);
        check_output("to done",   32'(o_done),   32'd0);
        tick();
        check_output("to busy lo", 32'(o_busy), 32'd0);

        // Reset in the middle of a bus cycle.
        apply_stimulus(2'd3, 32'h0000_0800, 32'h8888_8888);
        tick();
        apply_stimulus(2'd0, 32'h0, 32'h0);
        tick();
        check_output("mrst cyc before", 32'(o_wb_cyc), 32'd1);
        i_reset  = 1'b1;
        i_wb_ack = 1'b1;
        tick();
        i_reset  = 1'b0;
        i_wb_ack = 1'b0;
        check_output("mrst cyc",   32'(o_wb_cyc),  32'd0);
        check_output("mrst we",    32'(o_wb_we),   32'd0);
        check_output("mrst stb",   32'(o_wb_stb),  32'd0);
        check_output("mrst addr",  o_wb_addr,      32'h0);
        check_output("mrst dat",   o_wb_dat,       32'h0);
        check_output("mrst pulse", 32'({o_done, o_error}), 32'h0);
        check_output("mrst busy",  32'(o_busy),    32'd0);
        tick();
        check_output("mrst no pulse", 32'({o_done, o_error}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Execute-stage store engine for the CPU core. Sits between the instruction decoder and the shared Wishbone master mux, next to the load engine and the instruction fetcher.
- Takes a one-cycle store request (size, address, data), then:
  - checks alignment,
  - performs the byte-lane steering,
  - runs one Wishbone write cycle,
  - reports a done or error pulse to the main state machine.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles to wait for ack/err before aborting with o_error; 0 disables the timeout.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_reset  in  1  synchronous, active-high reset
- o_wb_addr  out  32  word-aligned bus address {addr[31:2],2'b00}
- o_wb_cyc  out  1  Wishbone cycle active
- o_wb_stb  out  4  per-byte-lane strobe/select, lane0 = dat[7:0]
- o_wb_we  out  1  write enable; 1 whenever o_wb_cyc=1
- o_wb_dat  out  32  lane-steered write data
- i_wb_dat  in  32  unused; present so all bus clients share one port list
- i_wb_ack  in  1  slave acknowledge
- i_wb_err  in  1  slave error
- i_store  in  2  request/size: 0 NONE, 1 BYTE, 2 HALF, 3 WORD
- i_data  in  32  store data, right-justified
- i_addr  in  32  byte address
- o_done  out  1  one-cycle pulse: store completed
- o_error  out  1  one-cycle pulse: misaligned, bus error or timeout
- o_busy  out  1  engine not IDLE

Behaviour:
- Reset: i_reset synchronous, active-high, on clock i_clk.
  - State returns to IDLE; timeout counter cleared.
  - Every output is 0: o_wb_addr, o_wb_dat, o_wb_stb, o_wb_cyc, o_wb_we, o_done, o_error, o_busy.
  - Reset during BUS drops o_wb_cyc on the next edge; no done/error pulse.
- States: IDLE, BUS, RESP.
- IDLE, i_store != 0 sampled at edge N:
  - Misaligned request: HALF with addr[0]=1, or WORD with addr[1:0]!=0.
    - o_error=1 in cycle N+1 for one cycle.
    - No bus cycle; stays IDLE.
  - Aligned request: enter BUS.
    - In cycle N+1: o_wb_cyc=1, o_wb_we=1; o_wb_addr, o_wb_stb and o_wb_dat registered and held stable until the cycle ends.
    - o_busy=1 from cycle N+1.
- Lane steering (little-endian):
  - BYTE: stb = 4'b0001 << addr[1:0]; dat = {4{data[7:0]}}.
  - HALF: stb = addr[1] ? 4'b1100 : 4'b0011; dat = {2{data[15:0]}}.
  - WORD: stb = 4'b1111; dat = data.
- BUS:
  - Exit condition: i_wb_ack or i_wb_err sampled high at edge M.
    - Next state RESP; o_wb_cyc, o_wb_stb and o_wb_we drop to 0 in cycle M+1.
    - o_done (ack only) or o_error (err) pulses in cycle M+1.
  - ack and err together: err wins; o_error only.
  - Timeout counter:
    - Increments each BUS cycle without ack/err.
    - On reaching TIMEOUT_CYCLES: abort as for err. The counter saturates; no wrap.
- RESP: single cycle, then IDLE; o_busy=0 again in cycle M+2.
  - Minimum request-to-request spacing with a zero-wait slave is 3 cycles.
- i_store while not IDLE is ignored; no queueing. The decoder issues only from EXECUTE_START.
- i_wb_ack/i_wb_err while IDLE or RESP are ignored.
- o_done and o_error are never high in the same cycle.
- The address is not range-checked; only alignment is checked.

Decomposition:
- Shared defines file gets:
  - STORE_NONE/BYTE/HALF/WORD (same 2-bit encoding as the LOAD_* constants);
  - a lane-select width constant (4).
- Optional sub-module: store_lane_steer, combinational size+addr[1:0]+data -> stb+dat. It is reusable by the load engine for lane extraction.
- The FSM and timeout counter stay in store_unit.

Test Plan:
- Aligned word: i_store=3, addr=0x100, data=0xDEADBEEF, ack 2 cycles after cyc. Required:
  - o_wb_addr=0x100, stb=1111, dat=0xDEADBEEF, we=1;
  - o_done pulses exactly once, the cycle after ack;
  - cyc low that cycle.
- Byte lanes: i_store=1, addr=0x203, data=0x000000A5. Required: addr=0x200, stb=1000, dat=0xA5A5A5A5. Repeat for addr[1:0]=0,1,2 and check the stb shift.
- Half: addr=0x302, data=0x1234 -> stb=1100, dat=0x12341234.
- Misaligned: half at 0x301, then word at 0x402. Required:
  - o_error one cycle after each request;
  - o_wb_cyc never asserted;
  - o_busy stays 0.
- Bus error and tie:
  - err alone -> o_error, no o_done.
  - ack+err in the same cycle -> o_error only.
  - Check the next request is accepted after RESP.
- Timeout and reset:
  - TIMEOUT_CYCLES=4, slave never responds -> o_error 5 cycles after cyc rises; cyc drops.
  - Separately, assert i_reset mid-BUS -> all outputs 0 the next cycle, no pulses.
